// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the timing/utility countdown timer.
//
// Holds the controller state encoding and the default counter width so the
// timer and anything that inspects its state agree on the same values.

package countdown_timer_pkg;

   // Default bit width of count, load_value and the internal period register.
   localparam int DEFAULT_WIDTH = 4;

   // Controller states. IDLE = no countdown, RUN = decrementing,
   // PAUSE = countdown active but held because enable dropped.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } timerState_t;

endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter / timer.
//
// A period is captured by a one-cycle load strobe. The count then decrements
// on every cycle that enable is high and raises a registered one-cycle done
// pulse when it reaches terminal count. With auto_reload high at terminal
// count the period is reloaded and counting continues, which turns the block
// into a periodic tick generator.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-low reset (0 = reset)
//   enable      in   1 = decrement this cycle, 0 = hold/pause
//   load        in   one-cycle strobe, captures load_value and starts
//   load_value  in   [WIDTH] unsigned period to load
//   auto_reload in   1 = reload period at terminal count and keep running
//   count       out  [WIDTH] remaining count (registered)
//   busy        out  1 while in RUN or PAUSE
//   paused      out  1 while in PAUSE
//   done        out  registered one-cycle pulse at terminal count

module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             paused,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   timerState_t      state;
   timerState_t      nextState;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] nextPeriod;
   logic [WIDTH-1:0] nextCount;
   logic             nextDone;

   // Next-state and datapath decision for one cycle. Load always beats the
   // countdown so a reload that lands on the terminal cycle restarts cleanly
   // with no done pulse. A zero load is treated as an immediate expiry: done
   // fires on the next edge and the timer stays idle. Terminal count is
   // recognised at count==1 so the transition to 0 and the done pulse land on
   // the same edge; count can therefore never be decremented past zero.
   // The count==0 branch in RUN/PAUSE is unreachable in normal operation and
   // only returns the controller to IDLE defensively.
   always_comb begin
      nextState  = state;
      nextCount  = count;
      nextPeriod = period;
      nextDone   = 1'b0;

      if (load) begin
         nextPeriod = load_value;
         nextCount  = load_value;
         if (load_value != '0) begin
            nextState = ST_RUN;
         end else begin
            nextDone  = 1'b1;
            nextState = ST_IDLE;
         end
      end else begin
         case (state)
            ST_RUN, ST_PAUSE: begin
               if (enable) begin
                  if (count == ONE) begin
                     nextDone = 1'b1;
                     if (auto_reload) begin
                        nextCount = period;
                        nextState = ST_RUN;
                     end else begin
                        nextCount = '0;
                        nextState = ST_IDLE;
                     end
                  end else if (count == '0) begin
                     nextState = ST_IDLE;
                  end else begin
                     nextCount = count - ONE;
                     nextState = ST_RUN;
                  end
               end else begin
                  nextState = ST_PAUSE;
               end
            end
            default: begin
               nextState = ST_IDLE;
            end
         endcase
      end
   end

   // State, count, period and done registers. Reset is synchronous and
   // active-low, and it wins over everything, so a countdown aborted by reset
   // never produces a done pulse.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= ST_IDLE;
         count  <= '0;
         period <= '0;
         done   <= 1'b0;
      end else begin
         state  <= nextState;
         count  <= nextCount;
         period <= nextPeriod;
         done   <= nextDone;
      end
   end

   // Status flags are decoded purely from the state register so they carry
   // no combinational path from the inputs.
   always_comb begin
      busy   = (state != ST_IDLE);
      paused = (state == ST_PAUSE);
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking directed testbench for countdown_timer.
//
// Inputs change 1 time unit after each rising clock edge and outputs are
// sampled at that same point, well away from the active edge. Every expected
// value below was worked out by hand from the timer's documented behaviour.

module tb_countdown_timer;

   localparam int WIDTH = 4;

   logic             clock;
   logic             reset;
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             paused;
   logic             done;

   int compared;
   int mismatched;
   int pulses;

   countdown_timer #(.WIDTH(WIDTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .load        (load),
      .load_value  (load_value),
      .auto_reload (auto_reload),
      .count       (count),
      .busy        (busy),
      .paused      (paused),
      .done        (done)
   );

   // 10-unit free-running clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive one full set of inputs.
   task automatic applyStimulus(input logic rst, input logic ld,
                                input logic [WIDTH-1:0] lv,
                                input logic en, input logic ar);
      reset       = rst;
      load        = ld;
      load_value  = lv;
      enable      = en;
      auto_reload = ar;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Single comparison point: counts and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Check every output of the timer against expectations.
   task automatic checkAll(input string tag, input int expCount, input logic expBusy,
                           input logic expPaused, input logic expDone);
      checkOutput({tag, " count"},  32'(count),  32'(expCount));
      checkOutput({tag, " busy"},   32'(busy),   32'(expBusy));
      checkOutput({tag, " paused"}, 32'(paused), 32'(expPaused));
      checkOutput({tag, " done"},   32'(done),   32'(expDone));
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      pulses     = 0;
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

      // 1: reset held with a load request pending; reset must win.
      applyStimulus(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkAll($sformatf("t1 reset%0d", i), 0, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
      checkAll("t1 release", 0, 1'b0, 1'b0, 1'b0);

      // 2: plain countdown of 5; enable high in the load cycle is ignored.
      applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
      tick();
      checkAll("t2 load", 5, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      for (int c = 4; c >= 1; c--) begin
         tick();
         checkAll($sformatf("t2 c%0d", c), c, 1'b1, 1'b0, 1'b0);
      end
      tick();
      checkAll("t2 term", 0, 1'b0, 1'b0, 1'b1);
      tick();
      checkAll("t2 after", 0, 1'b0, 1'b0, 1'b0);

      // 3: auto-reload with period 3 over 12 enabled cycles.
      applyStimulus(1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
      tick();
      checkAll("t3 load", 3, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (done) pulses++;
         checkAll($sformatf("t3 k%0d", k), (k % 3 == 0) ? 3 : 3 - (k % 3),
                  1'b1, 1'b0, (k % 3 == 0));
      end
      checkOutput("t3 pulses", 32'(pulses), 32'd4);

      // 4: load 6, two decrements, pause four cycles, resume to expiry.
      applyStimulus(1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
      tick();
      checkAll("t4 load", 6, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      checkAll("t4 c5", 5, 1'b1, 1'b0, 1'b0);
      tick();
      checkAll("t4 c4", 4, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      for (int p = 0; p < 4; p++) begin
         tick();
         checkAll($sformatf("t4 pause%0d", p), 4, 1'b1, 1'b1, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      for (int c = 3; c >= 1; c--) begin
         tick();
         checkAll($sformatf("t4 c%0d", c), c, 1'b1, 1'b0, 1'b0);
      end
      tick();
      checkAll("t4 term", 0, 1'b0, 1'b0, 1'b1);

      // 5: restart mid-countdown from 8 at count 2 with a new value of 4.
      applyStimulus(1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
      tick();
      checkAll("t5 load", 8, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      for (int c = 7; c >= 2; c--) begin
         tick();
         checkAll($sformatf("t5 c%0d", c), c, 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 4'd4, 1'b1, 1'b0);
      tick();
      checkAll("t5 reload", 4, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      for (int c = 3; c >= 1; c--) begin
         tick();
         checkAll($sformatf("t5 r%0d", c), c, 1'b1, 1'b0, 1'b0);
      end
      tick();
      checkAll("t5 term", 0, 1'b0, 1'b0, 1'b1);

      // 5b: load coincident with terminal count wins and suppresses done.
      applyStimulus(1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
      tick();
      checkAll("t5b load", 2, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      checkAll("t5b c1", 1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
      tick();
      checkAll("t5b clash", 5, 1'b1, 1'b0, 1'b0);

      // 6: zero load expires immediately, then reset aborts a countdown.
      applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      tick();
      checkAll("t6 zero", 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
      checkAll("t6 idle", 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
      tick();
      checkAll("t6 load", 7, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      for (int c = 6; c >= 3; c--) begin
         tick();
         checkAll($sformatf("t6 c%0d", c), c, 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      checkAll("t6 abort", 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      checkAll("t6 post", 0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter and timer. It is the decrementing counterpart of the team's 4-bit enable-gated up-counter.
- Software or upstream logic loads a period. The block counts down while enable is high and pulses done at terminal count.
- An optional auto-reload mode turns it into a periodic tick generator.
- Sits beside the up-counter in the timing/utility blocks and shares the same clock and reset.

Parameters:
- WIDTH, 4, bit width of count, load_value and internal period register.

Ports:
- clock  input  1  single system clock; all logic updates on its rising edge.
- reset  input  1  synchronous, active-low reset (sampled on clock rising edge; 0 = reset).
- enable  input  1  1 = decrement allowed this cycle; 0 = hold (pause).
- load  input  1  1-cycle strobe: capture load_value as period and start.
- load_value  input  WIDTH  period to load (unsigned).
- auto_reload  input  1  1 = on terminal count reload period and keep running; sampled every cycle.
- count  output  WIDTH  current remaining count (registered).
- busy  output  1  1 while a countdown is active (RUN or PAUSE).
- paused  output  1  1 while in PAUSE.
- done  output  1  registered one-cycle pulse at terminal count.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, count=0, period=0, busy=0, paused=0, done=0.
  - Reset overrides load and enable.
  - Reset mid-countdown aborts with no done pulse.
- States: IDLE, RUN, PAUSE; 2-bit encoding.
- done defaults to 0 every cycle unless set below.
- Priority per cycle: reset > load > terminal count > decrement/hold.
- load=1, any state:
  - period<=load_value, count<=load_value.
  - If load_value!=0: next state RUN. enable is ignored in the load cycle; the first decrement happens no earlier than the next cycle.
  - If load_value==0: count<=0, done<=1 on the next edge, next state IDLE (degenerate immediate expiry).
- IDLE, no load: count holds; busy=0; enable ignored.
- RUN, enable=1, count>1: count<=count-1, stay RUN.
- RUN or PAUSE, enable=1, count==1 (terminal):
  - done<=1.
  - If auto_reload=1: count<=period, next state RUN.
  - Else: count<=0, next state IDLE.
- RUN, enable=0: count holds, next state PAUSE.
- PAUSE, enable=1: decrement as in RUN (or terminal handling), next state RUN. Resume has no dead cycle.
- PAUSE, enable=0: hold, stay PAUSE.
- Outputs: busy = (state!=IDLE); paused = (state==PAUSE). Both are registered or decoded from the state register; no combinational path from inputs.
- Latency and periods:
  - Load of N (N≥1) with enable held high from the following cycle: done asserts in the cycle count shows 0 (non-reload), exactly N cycles after the load edge.
  - In reload mode, done repeats every N enabled cycles and count shows N in the done cycle.
- Arithmetic: unsigned, no wrap. count never decrements below 0; 0 is reached only via the terminal transition.
- Load during RUN/PAUSE restarts with the new value. No done is emitted for the aborted countdown.
- Load coincident with terminal count: load wins, no done.
- auto_reload changed mid-run: only its value in the terminal cycle matters.

Decomposition:
- Shared timer package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2;
  - default WIDTH.
- Single module; no sub-module needed.
- Next-state/decrement logic is a combinational block; state, count, period and done are registers.

Test Plan:
1. Hold reset=0 3 cycles with load=1, load_value=9 -> count=0, busy=0, done=0 throughout; release -> still IDLE.
2. load_value=5, load pulse, enable=1 after -> count 5,4,3,2,1,0; done=1 only in the count=0 cycle; busy falls the same cycle; count stays 0.
3. auto_reload=1, load_value=3, enable=1 for 12 cycles -> count 3,2,1,3,2,1,...; done pulses every 3rd cycle (4 pulses); busy stays 1.
4. load_value=6, enable=1 two cycles (count=4), enable=0 four cycles -> paused=1 and count=4 held; enable=1 -> 3,2,1,0, done once; total 10 cycles.
5. load_value=8, at count=2 pulse load with load_value=4 -> count=4 next cycle, then 3,2,1,0; exactly one done.
6. load_value=0 -> done=1 next cycle, busy=0, count=0. Then load 7, reset=0 at count=3 -> count=0, IDLE, no done.
